// File: rtl/systolic_collector.sv
// Result-row collector for the systolic array: buffers rows in a small FIFO,
// applies optional ReLU on write, and streams one word per beat with a per-matrix last flag.
module systolic_collector #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int ROW_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    relu_en,
    input  logic [2:0]              cols,
    input  logic [ROW_W-1:0]        rows,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] y1,
    input  logic signed [WIDTH-1:0] y2,
    input  logic signed [WIDTH-1:0] y3,
    input  logic signed [WIDTH-1:0] y4,
    input  logic signed [WIDTH-1:0] y5,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    full,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    function automatic logic [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] v,
                                              input logic en);
        return (en && v[WIDTH-1]) ? '0 : v;
    endfunction

    logic [5:0][WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [2:0]            col_idx;
    logic [ROW_W-1:0]      row_idx;
    logic [2:0]            cols_eff;
    logic [2:0]            cols_last;
    logic [ROW_W-1:0]      rows_eff;
    logic [ROW_W-1:0]      rows_last;
    logic                  push;
    logic                  accept;
    logic                  pop;
    logic                  last_col;
    logic                  last_row;

    always_comb begin
        cols_eff  = (cols == 3'd0 || cols == 3'd7) ? 3'd6 : cols;
        cols_last = cols_eff - 3'd1;
        rows_eff  = (rows == '0) ? ROW_W'(1) : rows;
        rows_last = rows_eff - ROW_W'(1);
    end

    assign m_valid = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign m_data  = m_valid ? mem[rd_ptr][col_idx] : '0;
    assign m_last  = m_valid && (col_idx == cols_last) && (row_idx == rows_last);

    // >= rather than == keeps the indices from running away if the config is changed mid-row.
    assign last_col = (col_idx >= cols_last);
    assign last_row = (row_idx >= rows_last);
    assign push     = in_valid && !full;
    assign accept   = m_valid && m_ready;
    assign pop      = accept && last_col;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            col_idx  <= '0;
            row_idx  <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            col_idx  <= '0;
            row_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (in_valid && full) overflow <= 1'b1;
            if (accept) begin
                if (last_col) begin
                    col_idx <= '0;
                    row_idx <= last_row ? '0 : row_idx + ROW_W'(1);
                end else begin
                    col_idx <= col_idx + 3'd1;
                end
            end
        end
    end

    // Row storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && push)
            mem[wr_ptr] <= {relu(y5, relu_en), relu(y4, relu_en), relu(y3, relu_en),
                            relu(y2, relu_en), relu(y1, relu_en), relu(y0, relu_en)};
    end

endmodule
